// File: rtl/main_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : main_mem_arbiter
// Purpose : Round-robin arbiter sharing one MainMem port between cpu and dma,
//           with one access in flight and a mem_wait watchdog.
// Revision: 1.0
// ============================================================================
module main_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SIZE_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_access_type,
    input  logic [SIZE_WIDTH-1:0] cpu_access_size,
    output logic                  cpu_wait,
    output logic                  cpu_done,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    input  logic                  dma_access_type,
    input  logic [SIZE_WIDTH-1:0] dma_access_size,
    output logic                  dma_wait,
    output logic                  dma_done,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_access_type,
    output logic [SIZE_WIDTH-1:0] mem_access_size,
    input  logic                  mem_wait,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  timeout_err,
    output logic                  grant_owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [15:0] C_TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    localparam bit          C_TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    grant_owner_q, grant_owner_d;
    logic                    mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    mem_type_q, mem_type_d;
    logic [SIZE_WIDTH-1:0]   mem_size_q, mem_size_d;
    logic                    cpu_done_q, cpu_done_d;
    logic                    dma_done_q, dma_done_d;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0]   dma_rdata_q, dma_rdata_d;
    logic                    timeout_err_q, timeout_err_d;
    logic [15:0]             cnt_q, cnt_d;

    logic                    w_cpu_elig;
    logic                    w_dma_elig;
    logic                    w_pick;
    logic                    w_finish;
    logic [DATA_WIDTH-1:0]   w_ret_data;
    logic [15:0]             w_cnt_inc;

    // A requester whose done is high this cycle is still holding req from the
    // finished access, so it is not eligible until the following cycle.
    assign w_cpu_elig = cpu_req & ~cpu_done_q;
    assign w_dma_elig = dma_req & ~dma_done_q;
    assign w_cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_owner_d = grant_owner_q;
        mem_req_d     = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_type_d    = mem_type_q;
        mem_size_d    = mem_size_q;
        cpu_done_d    = 1'b0;
        dma_done_d    = 1'b0;
        cpu_rdata_d   = '0;
        dma_rdata_d   = '0;
        timeout_err_d = 1'b0;
        cnt_d         = cnt_q;
        w_pick        = 1'b0;
        w_finish      = 1'b0;
        w_ret_data    = '0;

        case (state_q)
            IDLE: begin
                if (w_cpu_elig || w_dma_elig) begin
                    w_pick        = (w_cpu_elig && w_dma_elig) ? ~last_grant_q : w_dma_elig;
                    grant_owner_d = w_pick;
                    last_grant_d  = w_pick;
                    mem_addr_d    = w_pick ? dma_addr        : cpu_addr;
                    mem_wdata_d   = w_pick ? dma_wdata       : cpu_wdata;
                    mem_type_d    = w_pick ? dma_access_type : cpu_access_type;
                    mem_size_d    = w_pick ? dma_access_size : cpu_access_size;
                    mem_req_d     = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 16'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (!mem_wait) begin
                    w_finish   = 1'b1;
                    w_ret_data = mem_rdata;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (C_TIMEOUT_EN && (w_cnt_inc == C_TIMEOUT_LIM)) begin
                        w_finish      = 1'b1;
                        timeout_err_d = 1'b1;
                    end
                end
                if (w_finish) begin
                    state_d = IDLE;
                    if (grant_owner_q) begin
                        dma_done_d  = 1'b1;
                        dma_rdata_d = w_ret_data;
                    end else begin
                        cpu_done_d  = 1'b1;
                        cpu_rdata_d = w_ret_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            grant_owner_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_type_q    <= 1'b0;
            mem_size_q    <= '0;
            cpu_done_q    <= 1'b0;
            dma_done_q    <= 1'b0;
            cpu_rdata_q   <= '0;
            dma_rdata_q   <= '0;
            timeout_err_q <= 1'b0;
            cnt_q         <= 16'd0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_owner_q <= grant_owner_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_type_q    <= mem_type_d;
            mem_size_q    <= mem_size_d;
            cpu_done_q    <= cpu_done_d;
            dma_done_q    <= dma_done_d;
            cpu_rdata_q   <= cpu_rdata_d;
            dma_rdata_q   <= dma_rdata_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign cpu_wait        = cpu_req & ~cpu_done_q;
    assign dma_wait        = dma_req & ~dma_done_q;
    assign cpu_done        = cpu_done_q;
    assign dma_done        = dma_done_q;
    assign cpu_rdata       = cpu_rdata_q;
    assign dma_rdata       = dma_rdata_q;
    assign mem_req         = mem_req_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_access_type = mem_type_q;
    assign mem_access_size = mem_size_q;
    assign timeout_err     = timeout_err_q;
    assign grant_owner     = grant_owner_q;

endmodule
`default_nettype wire

// File: tb/tb_main_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_main_mem_arbiter
// Purpose : Scoreboard bench for main_mem_arbiter with a behavioural MainMem.
// Revision: 1.0
// ============================================================================
module tb_main_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, dma_req;
    logic [31:0] cpu_addr, dma_addr, cpu_wdata, dma_wdata;
    logic        cpu_access_type, dma_access_type;
    logic [1:0]  cpu_access_size, dma_access_size;
    logic        cpu_wait, dma_wait, cpu_done, dma_done;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        mem_req, mem_access_type, mem_wait;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_access_size;
    logic        timeout_err, grant_owner;

    typedef struct packed {
        logic [31:0] rdata;
        logic        tmo;
    } exp_t;

    exp_t        cpu_q[$];
    exp_t        dma_q[$];
    logic        glog[$];
    logic [31:0] alog[$];

    int n_checks = 0;
    int n_err    = 0;
    int mem_lat  = 0;
    bit mem_stuck = 1'b0;

    main_mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .SIZE_WIDTH(2), .TIMEOUT_CYCLES(4)
    ) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_access_type(cpu_access_type), .cpu_access_size(cpu_access_size),
        .cpu_wait(cpu_wait), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_access_type(dma_access_type), .dma_access_size(dma_access_size),
        .dma_wait(dma_wait), .dma_done(dma_done), .dma_rdata(dma_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_access_type(mem_access_type), .mem_access_size(mem_access_size),
        .mem_wait(mem_wait), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err), .grant_owner(grant_owner)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return 32'hDEADBEEF ^ a;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] d, input logic t);
        exp_t e;
        e.rdata = d;
        e.tmo   = t;
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit who, input int max_cyc);
        bit seen = 1'b0;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            @(negedge clk);
            seen = who ? dma_done : cpu_done;
        end
        check_eq(who ? "dma_done_seen" : "cpu_done_seen", 64'(seen), 64'd1);
    endtask

    // MainMem model: counts mem_lat busy cycles after the request pulse.
    initial begin
        bit busy = 1'b0;
        int rem  = 0;
        mem_wait  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 1'b0;
                mem_wait = 1'b0;
            end else if (mem_req) begin
                busy = 1'b1;
                rem = mem_lat;
                mem_wait = 1'b1;
            end else if (busy) begin
                if (mem_stuck || rem > 0) begin
                    mem_wait = 1'b1;
                    if (rem > 0) rem--;
                end else begin
                    mem_wait  = 1'b0;
                    mem_rdata = mem_val(mem_addr);
                    busy = 1'b0;
                end
            end else begin
                mem_wait = 1'b0;
            end
        end
    end

    // Scoreboard consumer and grant log.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (cpu_done) begin
                check_eq("cpu_done_expected", 64'(cpu_q.size() != 0), 64'd1);
                if (cpu_q.size() != 0) begin
                    e = cpu_q.pop_front();
                    check_eq("cpu_rdata", 64'(cpu_rdata), 64'(e.rdata));
                    check_eq("cpu_timeout_err", 64'(timeout_err), 64'(e.tmo));
                    check_eq("cpu_owner", 64'(grant_owner), 64'd0);
                    check_eq("dma_quiet", 64'({dma_done, dma_rdata}), 64'd0);
                end
            end
            if (dma_done) begin
                check_eq("dma_done_expected", 64'(dma_q.size() != 0), 64'd1);
                if (dma_q.size() != 0) begin
                    e = dma_q.pop_front();
                    check_eq("dma_rdata", 64'(dma_rdata), 64'(e.rdata));
                    check_eq("dma_timeout_err", 64'(timeout_err), 64'(e.tmo));
                    check_eq("dma_owner", 64'(grant_owner), 64'd1);
                    check_eq("cpu_quiet", 64'({cpu_done, cpu_rdata}), 64'd0);
                end
            end
            if (mem_req) begin
                glog.push_back(grant_owner);
                alog.push_back(mem_addr);
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check_eq(tag, 64'({mem_req, cpu_done, dma_done, timeout_err, grant_owner,
                           mem_access_type, mem_access_size}), 64'd0);
        check_eq({tag, "_data"}, 64'(cpu_rdata | dma_rdata | mem_addr | mem_wdata), 64'd0);
    endtask

    task automatic run_alternation(input logic first);
        cpu_addr = 32'h100; dma_addr = 32'h200;
        cpu_access_type = 1'b0; dma_access_type = 1'b0;
        mem_lat = 0;
        glog.delete(); alog.delete();
        cpu_req = 1'b1; dma_req = 1'b1;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    cpu_q.push_back(mk_exp(mem_val(32'h100), 1'b0));
                    wait_done(1'b0, 40);
                end
                cpu_req = 1'b0;
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    dma_q.push_back(mk_exp(mem_val(32'h200), 1'b0));
                    wait_done(1'b1, 40);
                end
                dma_req = 1'b0;
            end
        join
        check_eq("alt_grant_count", 64'(glog.size()), 64'd8);
        for (int i = 0; i < glog.size(); i++) begin
            logic own;
            own = first ^ i[0];
            check_eq("alt_owner", 64'(glog[i]), 64'(own));
            check_eq("alt_addr", 64'(alog[i]), own ? 64'h200 : 64'h100);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; dma_req = 1'b0;
        cpu_addr = '0; dma_addr = '0; cpu_wdata = '0; dma_wdata = '0;
        cpu_access_type = 1'b0; dma_access_type = 1'b0;
        cpu_access_size = '0; dma_access_size = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset_state");
        tick();
        rst = 1'b0;

        // Single cpu read with three busy cycles.
        cpu_addr = 32'h0; cpu_access_size = 2'd2; mem_lat = 3; cpu_req = 1'b1;
        cpu_q.push_back(mk_exp(32'hDEADBEEF, 1'b0));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq("t1_mem_req", 64'(mem_req), 64'(c == 1));
            check_eq("t1_cpu_wait", 64'(cpu_wait), 64'(c <= 5));
            check_eq("t1_cpu_done", 64'(cpu_done), 64'(c == 6));
            if (c == 6) cpu_req = 1'b0;
            tick();
        end

        // cpu holds req through done: request ignored on the done cycle.
        cpu_addr = 32'h4; mem_lat = 0; cpu_req = 1'b1;
        cpu_q.push_back(mk_exp(mem_val(32'h4), 1'b0));
        cpu_q.push_back(mk_exp(mem_val(32'h4), 1'b0));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq("t3_mem_req", 64'(mem_req), 64'(c == 1 || c == 5));
            check_eq("t3_cpu_done", 64'(cpu_done), 64'(c == 3 || c == 7));
            if (c == 7) cpu_req = 1'b0;
            tick();
        end

        // Last grant was cpu, so the tie goes to dma first.
        run_alternation(1'b1);

        // dma write while cpu is idle; fields change after grant.
        dma_addr = 32'h40; dma_wdata = 32'hCAFEF00D; dma_access_type = 1'b1;
        dma_access_size = 2'd2; mem_lat = 1; dma_req = 1'b1;
        dma_q.push_back(mk_exp(mem_val(32'h40), 1'b0));
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                seen = mem_req;
            end
            check_eq("t4_mem_req_seen", 64'(seen), 64'd1);
            check_eq("t4_type", 64'(mem_access_type), 64'd1);
            check_eq("t4_wdata", 64'(mem_wdata), 64'hCAFEF00D);
            check_eq("t4_addr", 64'(mem_addr), 64'h40);
            check_eq("t4_size", 64'(mem_access_size), 64'd2);
        end
        dma_addr = 32'hFFF0; dma_wdata = 32'h0; dma_access_type = 1'b0;
        wait_done(1'b1, 20);
        dma_req = 1'b0;
        check_eq("t4_addr_held", 64'(mem_addr), 64'h40);
        check_eq("t4_wdata_held", 64'(mem_wdata), 64'hCAFEF00D);
        tick();

        // Watchdog abort after four busy cycles, then a normal dma access.
        mem_stuck = 1'b1; cpu_addr = 32'h80; cpu_access_type = 1'b0; cpu_req = 1'b1;
        cpu_q.push_back(mk_exp(32'h0, 1'b1));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq("t5_mem_req", 64'(mem_req), 64'(c == 1));
            check_eq("t5_cpu_done", 64'(cpu_done), 64'(c == 6));
            check_eq("t5_timeout_err", 64'(timeout_err), 64'(c == 6));
            if (c == 6) begin
                cpu_req = 1'b0;
                mem_stuck = 1'b0;
            end
            tick();
        end
        dma_addr = 32'h300; dma_access_type = 1'b0; mem_lat = 2; dma_req = 1'b1;
        dma_q.push_back(mk_exp(mem_val(32'h300), 1'b0));
        wait_done(1'b1, 20);
        dma_req = 1'b0;
        tick();

        // Reset during WAIT drops the access.
        mem_stuck = 1'b1; cpu_addr = 32'h500; cpu_req = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        cpu_req = 1'b0;
        #1;
        check_zero_outputs("rst_mid_access");
        cpu_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        mem_stuck = 1'b0;
        repeat (6) tick();

        // After reset cpu wins the tie with normal latency.
        cpu_addr = 32'h10; dma_addr = 32'h20; mem_lat = 1;
        cpu_req = 1'b1; dma_req = 1'b1;
        cpu_q.push_back(mk_exp(mem_val(32'h10), 1'b0));
        dma_q.push_back(mk_exp(mem_val(32'h20), 1'b0));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("t6_mem_req", 64'(mem_req), 64'(c == 1));
            check_eq("t6_cpu_done", 64'(cpu_done), 64'(c == 4));
            if (c == 1) begin
                check_eq("t6_owner", 64'(grant_owner), 64'd0);
                check_eq("t6_addr", 64'(mem_addr), 64'h10);
            end
            if (c == 4) cpu_req = 1'b0;
            tick();
        end
        wait_done(1'b1, 20);
        dma_req = 1'b0;
        tick();

        run_alternation(1'b0);

        repeat (4) tick();
        check_eq("cpu_q_drained", 64'(cpu_q.size()), 64'd0);
        check_eq("dma_q_drained", 64'(dma_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
